// File: rtl/mem_access_stage_if.sv
// Data-memory port between the MEM stage (master) and the data memory (slave).
// The request fields stay stable from issue until the memory raises ready.
interface mem_access_stage_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
    logic            ready;
    logic [XLEN-1:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ready, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ready, rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores on the data-memory port, aligns and
// extends load data, and stalls upstream while an access is outstanding.
module mem_access_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic [2:0]        in_funct3,
    input  logic [XLEN-1:0]   in_alu_result,
    input  logic [XLEN-1:0]   in_store_data,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_reg_write,
    output logic              stall_o,
    mem_access_stage_if.master dmem,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [REG_AW-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              wb_exc
);
    typedef enum logic [0:0] {IDLE, BUSY} state_t;

    state_t            state_reg, state_next;
    logic [2:0]        f3_reg;
    logic [1:0]        off_reg;
    logic [REG_AW-1:0] rd_reg;

    logic              is_mem, f3_legal, misaligned, mem_err;
    logic [1:0]        off;
    logic [3:0]        be_next;
    logic [XLEN-1:0]   wdata_next;
    logic [XLEN-1:0]   load_data;
    logic [7:0]        rd_lane [4];
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;

    assign off    = in_alu_result[1:0];
    assign is_mem = in_mem_read | in_mem_write;

    // Request decode for the instruction currently presented by EX/MEM.
    always_comb begin
        f3_legal   = 1'b0;
        be_next    = 4'b1111;
        wdata_next = '0;
        if (in_mem_read)
            f3_legal = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010) ||
                       (in_funct3 == 3'b100) || (in_funct3 == 3'b101);
        else
            f3_legal = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010);
        misaligned = ((in_funct3[1:0] == 2'b01) && off[0]) ||
                     ((in_funct3[1:0] == 2'b10) && (off != 2'b00));
        mem_err    = (in_mem_read & in_mem_write) | ~f3_legal | misaligned;
        case (in_funct3[1:0])
            2'b00:   be_next = 4'b0001 << off;
            2'b01:   be_next = off[1] ? 4'b1100 : 4'b0011;
            default: be_next = 4'b1111;
        endcase
        if (in_mem_write) begin
            case (in_funct3[1:0])
                2'b00:   wdata_next = {4{in_store_data[7:0]}};
                2'b01:   wdata_next = {2{in_store_data[15:0]}};
                default: wdata_next = in_store_data;
            endcase
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign rd_lane[gi] = dmem.rdata[8*gi +: 8];
    end

    assign byte_sel = rd_lane[off_reg];
    assign half_sel = off_reg[1] ? {rd_lane[3], rd_lane[2]} : {rd_lane[1], rd_lane[0]};

    always_comb begin
        case (f3_reg)
            3'b000:  load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, byte_sel};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, half_sel};
            default: load_data = dmem.rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Stall is released in the completing cycle so EX/MEM can advance in step.
    always_comb begin
        state_next = state_reg;
        stall_o    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid && is_mem && !mem_err) begin
                    stall_o    = rst_n;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (dmem.ready) state_next = IDLE;
                else            stall_o    = rst_n;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem.req     <= 1'b0;
            dmem.we      <= 1'b0;
            dmem.addr    <= '0;
            dmem.be      <= '0;
            dmem.wdata   <= '0;
            f3_reg       <= '0;
            off_reg      <= '0;
            rd_reg       <= '0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            wb_exc       <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        if (!is_mem || mem_err) begin
                            wb_valid     <= 1'b1;
                            wb_rd        <= in_rd;
                            wb_data      <= in_alu_result;
                            wb_exc       <= is_mem;
                            wb_reg_write <= !is_mem && in_reg_write && (in_rd != '0);
                        end else begin
                            dmem.req   <= 1'b1;
                            dmem.we    <= in_mem_write;
                            dmem.addr  <= {in_alu_result[XLEN-1:2], 2'b00};
                            dmem.be    <= be_next;
                            dmem.wdata <= wdata_next;
                            f3_reg     <= in_funct3;
                            off_reg    <= off;
                            rd_reg     <= in_rd;
                        end
                    end
                end
                BUSY: begin
                    if (dmem.ready) begin
                        dmem.req <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_reg;
                        wb_exc   <= 1'b0;
                        if (dmem.we) begin
                            wb_reg_write <= 1'b0;
                            wb_data      <= '0;
                        end else begin
                            wb_reg_write <= (rd_reg != '0);
                            wb_data      <= load_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected writeback bundles are queued
// when an instruction is presented and matched when wb_valid fires.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_mem_read, in_mem_write, in_reg_write;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_result, in_store_data;
    logic [4:0]  in_rd;
    logic        stall_o, wb_valid, wb_reg_write, wb_exc;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;

    typedef struct {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exc;
        int          cyc;
    } wb_exp_t;

    wb_exp_t sb_q[$];
    wb_exp_t mon_e;

    mem_access_stage_if #(.XLEN(32)) dmem_bus ();

    mem_access_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_funct3(in_funct3), .in_alu_result(in_alu_result), .in_store_data(in_store_data),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .stall_o(stall_o),
        .dmem(dmem_bus),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_exc(wb_exc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            if (sb_q.size() == 0) begin
                chk("wb_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("wb_data", wb_data, mon_e.data);
                chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, mon_e.rw});
                chk("wb_exc", {31'd0, wb_exc}, {31'd0, mon_e.exc});
                if (mon_e.rw) chk("wb_rd", {27'd0, wb_rd}, {27'd0, mon_e.rd});
                chk("wb_latency", cyc, mon_e.cyc);
                $display("wb  rd=%0d rw=%b exc=%b data=%h cyc=%0d", wb_rd, wb_reg_write, wb_exc, wb_data, cyc);
            end
        end
    end

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a[1:0];
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {d[7:0], d[7:0], d[7:0], d[7:0]};
            2'b01:   return {d[15:0], d[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r);
        logic [31:0] sh;
        logic [15:0] h;
        sh = r >> (8 * a[1:0]);
        h  = a[1] ? r[31:16] : r[15:0];
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, sh[7:0]};
            3'b101:  return {16'd0, h};
            default: return r;
        endcase
    endfunction

    task automatic idle_inputs();
        in_valid = 0; in_mem_read = 0; in_mem_write = 0; in_reg_write = 0;
        in_funct3 = 0; in_alu_result = 0; in_store_data = 0; in_rd = 0;
    endtask

    task automatic alu_op(input logic [4:0] rd, input logic rw, input logic [31:0] res);
        wb_exp_t e;
        @(posedge clk); #1;
        in_valid = 1; in_rd = rd; in_reg_write = rw; in_alu_result = res;
        e.rw = rw && (rd != 0); e.rd = rd; e.data = res; e.exc = 0; e.cyc = cyc + 1;
        sb_q.push_back(e);
        @(negedge clk);
        chk("alu_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic err_op(input logic rd_f, input logic wr_f, input logic [2:0] f3, input logic [31:0] a);
        wb_exp_t e;
        @(posedge clk); #1;
        in_valid = 1; in_mem_read = rd_f; in_mem_write = wr_f; in_funct3 = f3;
        in_alu_result = a; in_rd = 5'd3; in_reg_write = rd_f;
        e.rw = 0; e.rd = 5'd3; e.data = a; e.exc = 1; e.cyc = cyc + 1;
        sb_q.push_back(e);
        @(negedge clk);
        chk("err_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("err_no_req", {31'd0, dmem_bus.req}, 32'd0);
    endtask

    task automatic mem_op(input logic wr, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] sdata, input int w,
                          input logic [31:0] rdata, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_data);
        wb_exp_t e;
        @(posedge clk); #1;
        in_valid = 1; in_mem_read = !wr; in_mem_write = wr; in_funct3 = f3;
        in_alu_result = a; in_store_data = sdata; in_rd = rd; in_reg_write = !wr;
        e.rw = !wr && (rd != 0); e.rd = rd; e.data = exp_data; e.exc = 0; e.cyc = cyc + 2 + w;
        sb_q.push_back(e);
        @(negedge clk);
        chk("mem_stall_idle", {31'd0, stall_o}, 32'd1);
        @(posedge clk); #1;
        idle_inputs();
        dmem_bus.ready = (w == 0);
        dmem_bus.rdata = rdata;
        for (int i = 0; i <= w; i++) begin
            @(negedge clk);
            chk("dmem_req", {31'd0, dmem_bus.req}, 32'd1);
            chk("dmem_we", {31'd0, dmem_bus.we}, {31'd0, wr});
            chk("dmem_addr", dmem_bus.addr, {a[31:2], 2'b00});
            chk("dmem_be", {28'd0, dmem_bus.be}, {28'd0, exp_be});
            chk("dmem_wdata", dmem_bus.wdata, exp_wdata);
            chk("busy_stall", {31'd0, stall_o}, (i == w) ? 32'd0 : 32'd1);
            if (i < w) begin
                @(posedge clk); #1;
                if (i == w - 1) dmem_bus.ready = 1;
            end
        end
        @(posedge clk); #1;
        dmem_bus.ready = 0;
        dmem_bus.rdata = 0;
    endtask

    initial begin
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a, sd, rdat;
        rst_n = 0;
        idle_inputs();
        dmem_bus.ready = 0;
        dmem_bus.rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'd0, dmem_bus.req}, 32'd0);
        chk("rst_we", {31'd0, dmem_bus.we}, 32'd0);
        chk("rst_addr", dmem_bus.addr, 32'd0);
        chk("rst_be", {28'd0, dmem_bus.be}, 32'd0);
        chk("rst_wdata", dmem_bus.wdata, 32'd0);
        chk("rst_wb", {26'd0, wb_valid, wb_reg_write, wb_exc, wb_rd == 0, stall_o, 1'b0}, 32'd4);
        chk("rst_wb_data", wb_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1;

        alu_op(5'd5, 1'b1, 32'h0000_1234);
        alu_op(5'd0, 1'b1, 32'hDEAD_BEEF);
        mem_op(0, 3'b000, 5'd7, 32'h103, 0, 0, 32'h80FF_0000, 4'b1000, 32'h0, 32'hFFFF_FF80);
        mem_op(0, 3'b101, 5'd8, 32'h102, 0, 0, 32'hBEEF_0000, 4'b1100, 32'h0, 32'h0000_BEEF);
        mem_op(0, 3'b001, 5'd8, 32'h102, 0, 1, 32'hBEEF_0000, 4'b1100, 32'h0, 32'hFFFF_BEEF);
        mem_op(1, 3'b000, 5'd4, 32'h201, 32'h1234_56AB, 3, 32'h0, 4'b0010, 32'hABAB_ABAB, 32'h0);
        mem_op(1, 3'b001, 5'd4, 32'h20A, 32'h1234_56AB, 0, 32'h0, 4'b1100, 32'h56AB_56AB, 32'h0);
        err_op(1, 0, 3'b010, 32'h102);
        err_op(1, 1, 3'b010, 32'h100);
        err_op(1, 0, 3'b011, 32'h100);
        err_op(0, 1, 3'b100, 32'h100);
        err_op(0, 1, 3'b001, 32'h101);
        mem_op(0, 3'b010, 5'd0, 32'h400, 0, 0, 32'h1357_9BDF, 4'b1111, 32'h0, 32'h1357_9BDF);

        // Reset in the middle of an outstanding access: nothing may be written back.
        @(posedge clk); #1;
        in_valid = 1; in_mem_read = 1; in_funct3 = 3'b010; in_alu_result = 32'h300; in_rd = 5'd6; in_reg_write = 1;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("abort_req_before", {31'd0, dmem_bus.req}, 32'd1);
        #2 rst_n = 0;
        #1;
        chk("abort_req", {31'd0, dmem_bus.req}, 32'd0);
        chk("abort_stall", {31'd0, stall_o}, 32'd0);
        chk("abort_wb", {31'd0, wb_valid}, 32'd0);
        $display("rst abort during BUSY");
        @(posedge clk); #1;
        rst_n = 1;
        mem_op(0, 3'b010, 5'd9, 32'h500, 0, 1, 32'hCAFE_F00D, 4'b1111, 32'h0, 32'hCAFE_F00D);

        for (int k = 0; k < 10; k++) begin
            wr = 1'($urandom_range(0, 1));
            case ($urandom_range(0, wr ? 2 : 4))
                0: f3 = 3'b000;
                1: f3 = 3'b001;
                2: f3 = 3'b010;
                3: f3 = 3'b100;
                default: f3 = 3'b101;
            endcase
            a = $urandom & 32'h0000_FFFC;
            if (f3[1:0] == 2'b00) a[1:0] = 2'($urandom_range(0, 3));
            if (f3[1:0] == 2'b01) a[1] = 1'($urandom_range(0, 1));
            sd = $urandom;
            rdat = $urandom;
            mem_op(wr, f3, 5'($urandom_range(0, 31)), a, sd, $urandom_range(0, 2), rdat,
                   m_be(f3, a), wr ? m_wdata(f3, sd) : 32'h0, wr ? 32'h0 : m_load(f3, a, rdat));
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access (MEM) stage of the five-stage pipeline, instantiated inside main between the EX/MEM and MEM/WB registers.
- Takes the executed instruction, performs loads and stores over a ready-handshaked data-memory port, and aligns and sign-extends load data.
- Produces a registered writeback bundle for WB.
- Asserts stall_o to freeze the upstream stages while a memory access is outstanding.

Parameters:
- XLEN, 32, datapath/address width; only 32 is supported.
- REG_AW, 5, register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  EX/MEM holds a valid instruction.
- in_mem_read  in  1  instruction is a load.
- in_mem_write  in  1  instruction is a store.
- in_funct3  in  3  access size/sign.
- in_alu_result  in  XLEN  effective address, or the ALU result for non-memory ops.
- in_store_data  in  XLEN  rs2 value.
- in_rd  in  REG_AW  destination register.
- in_reg_write  in  1  instruction writes rd.
- stall_o  out  1  hold EX/MEM and all earlier stages.
- dmem_req  out  1  memory request valid.
- dmem_we  out  1  1 = write.
- dmem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00}).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  XLEN  lane-replicated store data.
- dmem_ready  in  1  memory accepts/completes the request this cycle.
- dmem_rdata  in  XLEN  read word, valid when dmem_ready=1 and dmem_we=0.
- wb_valid  out  1  writeback bundle valid.
- wb_reg_write  out  1  write rd.
- wb_rd  out  REG_AW  destination.
- wb_data  out  XLEN  result; holds the faulting address when wb_exc=1.
- wb_exc  out  1  misaligned or illegal memory op.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All registered outputs are 0: dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, wb_valid, wb_reg_write, wb_rd, wb_data, wb_exc. stall_o=0.
- Reset asserted mid-access aborts the request immediately; no wb_valid is produced for that instruction.
- FSM states: IDLE, BUSY.
- IDLE, in_valid=0: wb_valid<=0; stall_o=0.
- IDLE, in_valid=1, no memory op: next cycle wb_valid=1, wb_data=in_alu_result, wb_rd=in_rd, wb_reg_write=in_reg_write & (in_rd!=0), wb_exc=0. Latency 1; stall_o=0.
- IDLE, memory op with an error: an error is any of in_mem_read&in_mem_write, an illegal funct3, or a misaligned address. Next cycle wb_valid=1, wb_exc=1, wb_reg_write=0, wb_data=in_alu_result. No dmem_req is issued; stall_o=0.
- IDLE, legal aligned memory op: stall_o=1 combinationally. Latch dmem_addr, dmem_we, dmem_be, dmem_wdata, rd, funct3 and addr[1:0]. Next state BUSY with dmem_req<=1. wb_valid<=0.
- BUSY, dmem_ready=0: dmem_req and all dmem_* outputs held stable; stall_o=1; EX/MEM inputs ignored.
- BUSY, dmem_ready=1: stall_o=0 in this same cycle. dmem_req<=0; state<=IDLE. Next cycle wb_valid=1.
  - Load: wb_data=extended lane; wb_reg_write=(rd!=0).
  - Store: wb_reg_write=0, wb_data=0.
- Memory op latency: wb_valid asserts 2 cycles after acceptance when dmem_ready is already high on the first BUSY cycle. Each wait cycle adds 1.
- Legal loads (funct3):
  - 000 LB: sign-extend byte at addr[1:0].
  - 001 LH: sign-extend half at addr[1].
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - Any other funct3 is illegal.
- Legal stores (funct3):
  - 000 SB: be=4'b0001<<addr[1:0], wdata={4{data[7:0]}}.
  - 001 SH: be=addr[1]?4'b1100:4'b0011, wdata={2{data[15:0]}}.
  - 010 SW: be=4'b1111.
  - Any other funct3 is illegal.
- For loads, dmem_be is the same lane mask as the equivalent store; dmem_wdata=0.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- wb_valid is a single-cycle pulse per instruction. Exactly one wb_valid per accepted instruction.

Test Plan:
- Non-memory op: in_alu_result=0x0000_1234, rd=5, reg_write=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=5, wb_reg_write=1; stall_o stays 0.
- LB at 0x103, dmem_ready=1 on the first BUSY cycle, rdata=0x80FF_0000 -> dmem_addr=0x100, dmem_be=4'b1000; wb_data=0xFFFF_FF80; 2-cycle latency.
- LHU at 0x102, rdata=0xBEEF_0000 -> wb_data=0x0000_BEEF. LH at the same address with the same rdata -> wb_data=0xFFFF_BEEF.
- SB at 0x201, data=0x1234_56AB, dmem_ready held 0 for 3 cycles:
  - dmem_be=4'b0010, dmem_wdata=0xABAB_ABAB, all dmem_* outputs stable for those 3 cycles;
  - stall_o=1 throughout the wait;
  - wb_reg_write=0 after completion.
- LW at 0x102 -> no dmem_req; next cycle wb_exc=1, wb_data=0x102, wb_reg_write=0. Load to rd=0 -> wb_reg_write=0.
- rst_n pulled low during BUSY -> immediately dmem_req=0, stall_o=0, wb_valid=0; after release the FSM accepts a new LW normally.
